pbkdf2_iter_ctrl: RTL and testbench
===================================

// Module: pbkdf2_iter_ctrl
// PURPOSE
//  Initiator side of the hmac_sha256 request/response interface: computes one PBKDF2-HMAC-SHA256
//  output block T_i = U_1 ^ U_2 ^ ... ^ U_c, where U_1 = PRF(P, S||INT(i)) and U_j = PRF(P, U_j-1).
//  Drives key/msg/len into the HMAC core, consumes each PRF result, XOR-accumulates, and iterates.
//  Sits between the host request port and a single hmac_sha256 instance; one block per request.
// PARAMETERS
//  ITER_W  16  width of iteration count c
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_i        in   1       reset, asynchronous, active-low (asserted when 0)
//  pw_i         in   512     password P, left-aligned, zero-padded right
//  salt_i       in   216     salt S, left-aligned, up to 27 bytes
//  salt_len_i   in   5       salt length in bytes, 0..27
//  iter_i       in   ITER_W  iteration count c; 0 treated as 1
//  blk_i        in   32      block index i (big-endian INT(i))
//  v_i          in   1       request valid
//  r_o          out  1       request ready
//  dk_o         out  256     result T_i
//  v_o          out  1       result valid
//  r_i          in   1       result ready
//  hmac_key_o   out  512     to hmac key_i
//  hmac_msg_o   out  440     to hmac msg_i, left-aligned
//  hmac_len_o   out  5       to hmac msg_len_i, bytes mod 32 (0 encodes 32)
//  hmac_v_o     out  1       to hmac v_i
//  hmac_r_i     in   1       from hmac r_o
//  hmac_prf_i   in   256     from hmac prf_o
//  hmac_v_i     in   1       from hmac v_o
//  hmac_r_o     out  1       to hmac r_i
// BEHAVIOUR
//  - Transfer on any port = valid & ready in same cycle; valid and payload held stable until accepted.
//  - Reset (rst_i=0, any time, incl. mid-iteration): state IDLE, counter/U/T/latches cleared,
//    v_o=0, hmac_v_o=0, hmac_r_o=0, dk_o=0, hmac_* data=0, r_o=0 while asserted.
//  - FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  - IDLE: r_o=1. On v_i: latch pw, salt, salt_len, iter (0->1), blk; cnt<=0; go ISSUE.
//  - ISSUE: hmac_v_o=1. cnt==0: msg = salt bytes [0..salt_len-1], then INT(blk) at byte offset
//    salt_len, remaining bytes 0 (salt bytes beyond salt_len masked to 0); len = salt_len+4.
//    cnt>0: msg = {U, 184'b0}; len = 0 (32 bytes). key = latched pw always.
//    On hmac_r_i: go WAIT (hmac_v_o deasserts next cycle).
//  - WAIT: hmac_r_o=1. On hmac_v_i: U<=prf; T<=(cnt==0)?prf:T^prf; cnt<=cnt+1;
//    if cnt+1==iter go DONE else go ISSUE.
//  - DONE: v_o=1, dk_o=T (registered, stable). On r_i: go IDLE; r_o not asserted in DONE.
//  - Only one HMAC request outstanding; no new host request accepted until result taken.
//  - hmac_v_i outside WAIT ignored; hmac_r_i outside ISSUE ignored.
//  - Latency: 1 cycle accept->ISSUE; per iteration 1 cycle ISSUE->WAIT after accept plus HMAC
//    latency; 1 cycle from last prf capture to v_o. Back-to-back requests legal from IDLE.
//  - cnt ITER_W bits; iter=2^ITER_W-1 must complete without wrap.
// TESTING
//  1 Mock HMAC, salt "salt" len 4, blk 1, iter 1 -> hmac_msg_o = 73616c74_00000001 then zeros,
//    hmac_len_o=8; mock prf=A -> dk_o=A, v_o after 1 cycle.
//  2 Real hmac_sha256, P="password", S="salt", c=1, i=1 ->
//    dk_o=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b; c=2 ->
//    ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
//  3 Mock HMAC, iter 3, prfs 0x1,0x2,0x4 -> 2nd/3rd msgs {prev prf,0}, len 0; dk_o=0x7.
//  4 Salt len 27 with garbage beyond, and salt len 0 -> INT(i) at bytes 27..30 (len 31) / bytes 0..3
//    (len 4); trailing bytes zero.
//  5 Random stalls on hmac_r_i, hmac_v_i, r_i; iter_i=0 -> payloads stable while stalled, exactly
//    one HMAC call for iter 0, no dropped/duplicated transfers.
//  6 Assert rst_i low mid-WAIT on iter 4 -> all outputs 0 immediately; next request completes correctly.

Source files
------------

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 single-block iteration controller: drives one external HMAC core
// through U_1..U_c and XOR-accumulates them into T_i.
module pbkdf2_iter_ctrl #(
   parameter int unsigned ITER_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [511:0]      pw_i,
   input  logic [215:0]      salt_i,
   input  logic [4:0]        salt_len_i,
   input  logic [ITER_W-1:0] iter_i,
   input  logic [31:0]       blk_i,
   input  logic              v_i,
   output logic              r_o,
   output logic [255:0]      dk_o,
   output logic              v_o,
   input  logic              r_i,
   output logic [511:0]      hmac_key_o,
   output logic [439:0]      hmac_msg_o,
   output logic [4:0]        hmac_len_o,
   output logic              hmac_v_o,
   input  logic              hmac_r_i,
   input  logic [255:0]      hmac_prf_i,
   input  logic              hmac_v_i,
   output logic              hmac_r_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [511:0]        pw_q, pw_d;
   logic [215:0]        salt_q, salt_d;
   logic [4:0]          slen_q, slen_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [31:0]         blk_q, blk_d;
   logic [ITER_W-1:0]   cnt_q, cnt_d;
   logic [255:0]        u_q, u_d;
   logic [255:0]        t_q, t_d;
   logic [ITER_W-1:0]   cnt_inc;
   logic [439:0]        first_msg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         pw_q    <= '0;
         salt_q  <= '0;
         slen_q  <= '0;
         iter_q  <= '0;
         blk_q   <= '0;
         cnt_q   <= '0;
         u_q     <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         pw_q    <= pw_d;
         salt_q  <= salt_d;
         slen_q  <= slen_d;
         iter_q  <= iter_d;
         blk_q   <= blk_d;
         cnt_q   <= cnt_d;
         u_q     <= u_d;
         t_q     <= t_d;
      end
   end

   // First PRF message: salt[0..slen-1] || INT(blk) || zeros; salt bytes past slen are masked.
   always_comb begin
      first_msg = '0;
      for (int unsigned k = 0; k < 27; k++) begin
         if (k < {27'd0, slen_q}) begin
            first_msg[439-8*k -: 8] = salt_q[215-8*k -: 8];
         end
      end
      for (int unsigned j = 0; j < 4; j++) begin
         first_msg[439-8*({27'd0, slen_q}+j) -: 8] = blk_q[31-8*j -: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      pw_d     = pw_q;
      salt_d   = salt_q;
      slen_d   = slen_q;
      iter_d   = iter_q;
      blk_d    = blk_q;
      cnt_d    = cnt_q;
      u_d      = u_q;
      t_d      = t_q;
      cnt_inc  = cnt_q + ITER_ONE;
      r_o      = 1'b0;
      v_o      = 1'b0;
      hmac_v_o = 1'b0;
      hmac_r_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Gated by rst_i so the host never sees ready while reset is held.
            r_o = rst_i;
            if (v_i) begin
               pw_d    = pw_i;
               salt_d  = salt_i;
               slen_d  = salt_len_i;
               iter_d  = (iter_i == '0) ? ITER_ONE : iter_i;
               blk_d   = blk_i;
               cnt_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            hmac_v_o = 1'b1;
            if (hmac_r_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            hmac_r_o = 1'b1;
            if (hmac_v_i) begin
               u_d     = hmac_prf_i;
               t_d     = (cnt_q == '0) ? hmac_prf_i : (t_q ^ hmac_prf_i);
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == iter_q) ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            v_o = 1'b1;
            if (r_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hmac_key_o = '0;
      hmac_msg_o = '0;
      hmac_len_o = '0;
      if (state_q == S_ISSUE) begin
         hmac_key_o = pw_q;
         if (cnt_q == '0) begin
            hmac_msg_o = first_msg;
            hmac_len_o = slen_q + 5'd4;
         end else begin
            hmac_msg_o = {u_q, 184'b0};
            hmac_len_o = 5'd0;
         end
      end
   end

   assign dk_o = t_q;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Directed bench for pbkdf2_iter_ctrl with a bench-driven mock HMAC core.
module tb_pbkdf2_iter_ctrl;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [511:0]  pw_i;
   logic [215:0]  salt_i;
   logic [4:0]    salt_len_i;
   logic [15:0]   iter_i;
   logic [31:0]   blk_i;
   logic          v_i;
   logic          r_o;
   logic [255:0]  dk_o;
   logic          v_o;
   logic          r_i;
   logic [511:0]  hmac_key_o;
   logic [439:0]  hmac_msg_o;
   logic [4:0]    hmac_len_o;
   logic          hmac_v_o;
   logic          hmac_r_i;
   logic [255:0]  hmac_prf_i;
   logic          hmac_v_i;
   logic          hmac_r_o;

   int checks   = 0;
   int failures = 0;
   int hreq_cnt = 0;

   localparam logic [511:0] PW   = {64'h70617373776f7264, 448'h0};
   localparam logic [215:0] SALT = {32'h73616c74, 184'h0};
   localparam logic [215:0] SALT_G = 216'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B;

   logic [439:0] c_msg;
   logic [4:0]   c_len;
   logic [511:0] c_key;
   logic [255:0] c_dk;
   bit           c_stable;
   bit           c_to;

   pbkdf2_iter_ctrl #(.ITER_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .pw_i(pw_i), .salt_i(salt_i), .salt_len_i(salt_len_i),
      .iter_i(iter_i), .blk_i(blk_i), .v_i(v_i), .r_o(r_o), .dk_o(dk_o), .v_o(v_o), .r_i(r_i),
      .hmac_key_o(hmac_key_o), .hmac_msg_o(hmac_msg_o), .hmac_len_o(hmac_len_o),
      .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i), .hmac_prf_i(hmac_prf_i),
      .hmac_v_i(hmac_v_i), .hmac_r_o(hmac_r_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // All driver tasks are entered and return on a falling edge.
   task automatic send_req(input logic [511:0] pw, input logic [215:0] salt, input logic [4:0] slen,
                           input logic [15:0] iter, input logic [31:0] blk, output bit to);
      int n = 0;
      pw_i = pw; salt_i = salt; salt_len_i = slen; iter_i = iter; blk_i = blk; v_i = 1'b1;
      while (!r_o && n < 50) begin @(negedge clk_i); n++; end
      to = (n >= 50);
      @(negedge clk_i);
      v_i = 1'b0;
      pw_i = '1; salt_i = '1; salt_len_i = 5'd17; iter_i = 16'hFFFF; blk_i = '1;
   endtask

   task automatic hmac_accept(input int stall, output logic [439:0] msg, output logic [4:0] len,
                              output logic [511:0] key, output bit stable, output bit to);
      int n = 0;
      while (!hmac_v_o && n < 50) begin @(negedge clk_i); n++; end
      to = (n >= 50);
      msg = hmac_msg_o; len = hmac_len_o; key = hmac_key_o; stable = 1'b1;
      repeat (stall) begin
         @(negedge clk_i);
         if (hmac_msg_o !== msg || hmac_len_o !== len || hmac_key_o !== key || hmac_v_o !== 1'b1)
            stable = 1'b0;
      end
      hmac_r_i = 1'b1;
      @(negedge clk_i);
      hmac_r_i = 1'b0;
      hreq_cnt++;
   endtask

   task automatic hmac_respond(input logic [255:0] prf, input int stall, output bit to);
      int n = 0;
      repeat (stall) @(negedge clk_i);
      hmac_v_i = 1'b1; hmac_prf_i = prf;
      while (!hmac_r_o && n < 50) begin @(negedge clk_i); n++; end
      to = (n >= 50);
      @(negedge clk_i);
      hmac_v_i = 1'b0; hmac_prf_i = '0;
   endtask

   task automatic take_result(input int stall, output logic [255:0] dk, output bit stable, output bit to);
      int n = 0;
      while (!v_o && n < 50) begin @(negedge clk_i); n++; end
      to = (n >= 50);
      dk = dk_o; stable = 1'b1;
      repeat (stall) begin
         @(negedge clk_i);
         if (dk_o !== dk || v_o !== 1'b1) stable = 1'b0;
      end
      r_i = 1'b1;
      @(negedge clk_i);
      r_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      v_i = 1'b1; pw_i = PW; salt_i = SALT; salt_len_i = 5'd4; iter_i = 16'd1; blk_i = 32'd1;
      r_i = 1'b0; hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({r_o, v_o, hmac_v_o, hmac_r_o} !== 4'b0000) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0000", {r_o, v_o, hmac_v_o, hmac_r_o});
      end
      checks++;
      if (dk_o !== '0 || hmac_msg_o !== '0 || hmac_len_o !== '0 || hmac_key_o !== '0) begin
         failures++; $display("FAIL reset_data dk=%h len=%0d", dk_o, hmac_len_o);
      end
      v_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (r_o !== 1'b1 || hmac_v_o !== 1'b0) begin
         failures++; $display("FAIL reset_release r_o=%b hmac_v_o=%b exp 1/0", r_o, hmac_v_o);
      end
   endtask

   task automatic test_single();
      logic [255:0] a = {8{32'hDEADBEEF}};
      send_req(PW, SALT, 5'd4, 16'd1, 32'd1, c_to);
      checks++;
      if (c_to || hmac_v_o !== 1'b1 || r_o !== 1'b0) begin
         failures++; $display("FAIL single_issue to=%0d hmac_v_o=%b r_o=%b exp 0/1/0", c_to, hmac_v_o, r_o);
      end
      hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
      checks++;
      if (c_msg !== {32'h73616c74, 32'h00000001, 376'h0} || c_len !== 5'd8) begin
         failures++; $display("FAIL single_msg got=%h len=%0d exp len=8", c_msg, c_len);
      end
      checks++;
      if (c_key !== PW) begin
         failures++; $display("FAIL single_key got=%h exp=%h", c_key, PW);
      end
      checks++;
      if (hmac_v_o !== 1'b0 || hmac_r_o !== 1'b1) begin
         failures++; $display("FAIL single_wait hmac_v_o=%b hmac_r_o=%b exp 0/1", hmac_v_o, hmac_r_o);
      end
      hmac_respond(a, 0, c_to);
      checks++;
      if (c_to || v_o !== 1'b1 || dk_o !== a || r_o !== 1'b0) begin
         failures++; $display("FAIL single_done v_o=%b dk=%h r_o=%b exp v_o=1 dk=%h r_o=0", v_o, dk_o, r_o, a);
      end
      take_result(0, c_dk, c_stable, c_to);
      checks++;
      if (v_o !== 1'b0 || r_o !== 1'b1) begin
         failures++; $display("FAIL single_idle v_o=%b r_o=%b exp 0/1", v_o, r_o);
      end
   endtask

   task automatic test_iterate();
      logic [255:0] prfs [3] = '{256'h1, 256'h2, 256'h4};
      send_req(PW, SALT, 5'd4, 16'd3, 32'd2, c_to);
      for (int i = 0; i < 3; i++) begin
         hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
         checks++;
         if (i == 0) begin
            if (c_to || c_msg !== {32'h73616c74, 32'h00000002, 376'h0} || c_len !== 5'd8) begin
               failures++; $display("FAIL iter_msg%0d got=%h len=%0d", i, c_msg, c_len);
            end
         end else begin
            if (c_to || c_msg !== {prfs[i-1], 184'h0} || c_len !== 5'd0) begin
               failures++; $display("FAIL iter_msg%0d got=%h len=%0d exp len=0", i, c_msg, c_len);
            end
         end
         hmac_respond(prfs[i], 1, c_to);
      end
      take_result(0, c_dk, c_stable, c_to);
      checks++;
      if (c_to || c_dk !== 256'h7) begin
         failures++; $display("FAIL iter_dk got=%h exp=7", c_dk);
      end
   endtask

   task automatic test_salt_edges();
      logic [4:0]   lens [3] = '{5'd27, 5'd5, 5'd0};
      logic [439:0] exps [3] = '{{SALT_G, 32'hCAFE0007, 192'h0},
                                 {40'h0102030405, 32'hCAFE0007, 368'h0},
                                 {32'hCAFE0007, 408'h0}};
      logic [4:0]   elen [3] = '{5'd31, 5'd9, 5'd4};
      for (int i = 0; i < 3; i++) begin
         send_req(PW, SALT_G, lens[i], 16'd1, 32'hCAFE0007, c_to);
         hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
         checks++;
         if (c_to || c_msg !== exps[i] || c_len !== elen[i]) begin
            failures++; $display("FAIL salt_len%0d got=%h len=%0d exp=%h len=%0d", lens[i], c_msg, c_len, exps[i], elen[i]);
         end
         hmac_respond({224'h0, 32'h100 + 32'(i)}, 0, c_to);
         take_result(0, c_dk, c_stable, c_to);
         checks++;
         if (c_to || c_dk !== {224'h0, 32'h100 + 32'(i)}) begin
            failures++; $display("FAIL salt_dk%0d got=%h", i, c_dk);
         end
      end
   endtask

   task automatic test_stalls();
      logic [255:0] p = {4{64'h0123456789ABCDEF}};
      int base;
      base = hreq_cnt;
      send_req(PW, SALT, 5'd4, 16'd0, 32'd9, c_to);
      hmac_v_i = 1'b1; hmac_prf_i = {256{1'b1}};
      hmac_accept(3, c_msg, c_len, c_key, c_stable, c_to);
      hmac_v_i = 1'b0; hmac_prf_i = '0;
      checks++;
      if (c_to || !c_stable || c_msg !== {32'h73616c74, 32'h00000009, 376'h0}) begin
         failures++; $display("FAIL stall_req to=%0d stable=%0d msg=%h", c_to, c_stable, c_msg);
      end
      hmac_respond(p, 4, c_to);
      take_result(3, c_dk, c_stable, c_to);
      checks++;
      if (c_to || !c_stable || c_dk !== p) begin
         failures++; $display("FAIL stall_result to=%0d stable=%0d dk=%h exp=%h", c_to, c_stable, c_dk, p);
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (hmac_v_o !== 1'b0 || r_o !== 1'b1 || hreq_cnt - base != 1) begin
         failures++; $display("FAIL stall_one_call hmac_v_o=%b r_o=%b calls=%0d exp 0/1/1", hmac_v_o, r_o, hreq_cnt - base);
      end
   endtask

   task automatic test_reset_mid();
      send_req(PW, SALT, 5'd4, 16'd4, 32'd1, c_to);
      hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
      hmac_respond(256'h100, 0, c_to);
      hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
      hmac_respond(256'h200, 0, c_to);
      hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
      rst_i = 1'b0;
      #1;
      checks++;
      if ({r_o, v_o, hmac_v_o, hmac_r_o} !== 4'b0000 || dk_o !== '0 || hmac_msg_o !== '0 ||
          hmac_len_o !== '0 || hmac_key_o !== '0) begin
         failures++; $display("FAIL midreset_outputs ctrl=%b dk=%h", {r_o, v_o, hmac_v_o, hmac_r_o}, dk_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      send_req(PW, SALT, 5'd4, 16'd2, 32'd3, c_to);
      hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
      checks++;
      if (c_to || c_msg !== {32'h73616c74, 32'h00000003, 376'h0} || c_len !== 5'd8) begin
         failures++; $display("FAIL midreset_msg got=%h len=%0d", c_msg, c_len);
      end
      hmac_respond(256'h10, 0, c_to);
      hmac_accept(0, c_msg, c_len, c_key, c_stable, c_to);
      hmac_respond(256'h30, 0, c_to);
      take_result(0, c_dk, c_stable, c_to);
      checks++;
      if (c_to || c_dk !== 256'h20) begin
         failures++; $display("FAIL midreset_dk got=%h exp=20", c_dk);
      end
   endtask

   initial begin
      @(negedge clk_i);
      test_reset();
      test_single();
      test_iterate();
      test_salt_edges();
      test_stalls();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
